// File: rtl/ex_stage.sv
// Execute stage of the five-stage MIPS pipeline: ALU, load/store address generation,
// HI/LO ownership and a 32-step restoring divider that stalls the pipe while busy.
module ex_stage (
  input  logic         clk,
  input  logic         rst,
  input  logic [5:0]   stall,
  input  logic [158:0] id_to_ex_bus,
  output logic [75:0]  ex_to_mem_bus,
  output logic [37:0]  ex_to_rf_bus,
  output logic         data_sram_en,
  output logic [3:0]   data_sram_wen,
  output logic [31:0]  data_sram_addr,
  output logic [31:0]  data_sram_wdata,
  output logic         stallreq_for_ex,
  output logic         ex_is_load
);

  localparam int  ID_TO_EX_WD = 159;
  localparam logic STOP       = 1'b1;
  localparam logic NOSTOP     = 1'b0;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_BUSY,
    DIV_DONE
  } div_state_t;

  logic [ID_TO_EX_WD-1:0] r_id_ex;
  logic [31:0]            r_hi;
  logic [31:0]            r_lo;
  div_state_t             r_div_state;
  logic [4:0]             r_div_cnt;
  logic [31:0]            r_div_rem;
  logic [31:0]            r_div_quo;
  logic [31:0]            r_div_dvsr;
  logic                   r_div_qneg;
  logic                   r_div_rneg;
  logic                   r_div_zero;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_id_ex <= '0;
    end else if (stall[2] == STOP && stall[3] == NOSTOP) begin
      r_id_ex <= '0;
    end else if (stall[2] == NOSTOP) begin
      r_id_ex <= id_to_ex_bus;
    end
  end

  logic [31:0] w_pc;
  logic [31:0] w_inst;
  logic [11:0] w_alu_op;
  logic [2:0]  w_sel_src1;
  logic [3:0]  w_sel_src2;
  logic        w_ram_en;
  logic [3:0]  w_ram_wen;
  logic        w_rf_we;
  logic [4:0]  w_rf_waddr;
  logic        w_sel_rf_res;
  logic [31:0] w_rdata1;
  logic [31:0] w_rdata2;

  assign {w_pc, w_inst, w_alu_op, w_sel_src1, w_sel_src2, w_ram_en, w_ram_wen,
          w_rf_we, w_rf_waddr, w_sel_rf_res, w_rdata1, w_rdata2} = r_id_ex;

  logic [5:0]  w_opcode;
  logic [5:0]  w_func;
  logic        w_rtype;
  logic        w_is_mfhi;
  logic        w_is_mflo;
  logic        w_is_mthi;
  logic        w_is_mtlo;
  logic        w_is_div;
  logic        w_is_divu;
  logic        w_is_div_any;
  logic [31:0] w_imm_sext;
  logic [31:0] w_imm_zext;

  assign w_opcode     = w_inst[31:26];
  assign w_func       = w_inst[5:0];
  assign w_rtype      = (w_opcode == 6'b000000);
  // mfhi/mflo carry zero rs/rt fields in every legal encoding
  assign w_is_mfhi    = w_rtype && (w_func == 6'b010000) && (w_inst[25:16] == 10'd0);
  assign w_is_mflo    = w_rtype && (w_func == 6'b010010) && (w_inst[25:16] == 10'd0);
  assign w_is_mthi    = w_rtype && (w_func == 6'b010001);
  assign w_is_mtlo    = w_rtype && (w_func == 6'b010011);
  assign w_is_div     = w_rtype && (w_func == 6'b011010);
  assign w_is_divu    = w_rtype && (w_func == 6'b011011);
  assign w_is_div_any = w_is_div || w_is_divu;
  assign w_imm_sext   = {{16{w_inst[15]}}, w_inst[15:0]};
  assign w_imm_zext   = {16'd0, w_inst[15:0]};

  logic [31:0] w_src1;
  logic [31:0] w_src2;

  always_comb begin
    w_src1 = '0;
    if (w_sel_src1[0]) w_src1 = w_src1 | w_rdata1;
    if (w_sel_src1[1]) w_src1 = w_src1 | w_pc;
    if (w_sel_src1[2]) w_src1 = w_src1 | {27'd0, w_inst[10:6]};
  end

  always_comb begin
    w_src2 = '0;
    if (w_sel_src2[0]) w_src2 = w_src2 | w_rdata2;
    if (w_sel_src2[1]) w_src2 = w_src2 | w_imm_sext;
    if (w_sel_src2[2]) w_src2 = w_src2 | 32'd8;
    if (w_sel_src2[3]) w_src2 = w_src2 | w_imm_zext;
  end

  logic [31:0] w_alu_res;

  // alu_op is one-hot, so OR-ing the masked terms acts as a mux
  always_comb begin
    w_alu_res = '0;
    if (w_alu_op[11]) w_alu_res = w_alu_res | (w_src1 + w_src2);
    if (w_alu_op[10]) w_alu_res = w_alu_res | (w_src1 - w_src2);
    if (w_alu_op[9])  w_alu_res = w_alu_res | {31'd0, ($signed(w_src1) < $signed(w_src2))};
    if (w_alu_op[8])  w_alu_res = w_alu_res | {31'd0, (w_src1 < w_src2)};
    if (w_alu_op[7])  w_alu_res = w_alu_res | (w_src1 & w_src2);
    if (w_alu_op[6])  w_alu_res = w_alu_res | ~(w_src1 | w_src2);
    if (w_alu_op[5])  w_alu_res = w_alu_res | (w_src1 | w_src2);
    if (w_alu_op[4])  w_alu_res = w_alu_res | (w_src1 ^ w_src2);
    if (w_alu_op[3])  w_alu_res = w_alu_res | (w_src2 << w_src1[4:0]);
    if (w_alu_op[2])  w_alu_res = w_alu_res | (w_src2 >> w_src1[4:0]);
    if (w_alu_op[1])  w_alu_res = w_alu_res | $unsigned($signed(w_src2) >>> w_src1[4:0]);
    if (w_alu_op[0])  w_alu_res = w_alu_res | {w_src2[15:0], 16'd0};
  end

  logic [31:0] w_ex_result;

  assign w_ex_result = w_is_mfhi ? r_hi : (w_is_mflo ? r_lo : w_alu_res);

  logic        w_is_sb;
  logic        w_is_sh;
  logic        w_is_sw;
  logic [31:0] w_addr;
  logic [3:0]  w_wen;
  logic [31:0] w_wdata;

  assign w_is_sb = (w_opcode == 6'b101000);
  assign w_is_sh = (w_opcode == 6'b101001);
  assign w_is_sw = (w_opcode == 6'b101011);
  assign w_addr  = w_rdata1 + w_imm_sext;

  always_comb begin
    w_wen   = 4'b0000;
    w_wdata = w_rdata2;
    if (w_is_sb) w_wdata = {4{w_rdata2[7:0]}};
    if (w_is_sh) w_wdata = {2{w_rdata2[15:0]}};
    if (w_ram_en) begin
      if (w_is_sb) w_wen = 4'b0001 << w_addr[1:0];
      if (w_is_sh) w_wen = 4'b0011 << w_addr[1:0];
      if (w_is_sw) w_wen = 4'b1111;
    end
  end

  logic [31:0] w_abs1;
  logic [31:0] w_abs2;
  logic [32:0] w_div_shift;
  logic        w_div_ge;
  logic [32:0] w_div_diff;
  logic [31:0] w_div_quo_fin;
  logic [31:0] w_div_rem_fin;
  logic        w_id_load;

  assign w_abs1        = (w_is_div && w_rdata1[31]) ? (32'd0 - w_rdata1) : w_rdata1;
  assign w_abs2        = (w_is_div && w_rdata2[31]) ? (32'd0 - w_rdata2) : w_rdata2;
  assign w_div_shift   = {r_div_rem, r_div_quo[31]};
  assign w_div_ge      = (w_div_shift >= {1'b0, r_div_dvsr});
  assign w_div_diff    = w_div_shift - {1'b0, r_div_dvsr};
  assign w_div_quo_fin = r_div_zero ? 32'hFFFF_FFFF : (r_div_qneg ? (32'd0 - r_div_quo) : r_div_quo);
  assign w_div_rem_fin = r_div_rneg ? (32'd0 - r_div_rem) : r_div_rem;
  assign w_id_load     = (stall[2] == NOSTOP) || (stall[3] == NOSTOP);

  // Dividend shifts out of r_div_quo MSB-first while quotient bits shift in at the bottom
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div_state <= DIV_IDLE;
      r_div_cnt   <= '0;
      r_div_rem   <= '0;
      r_div_quo   <= '0;
      r_div_dvsr  <= '0;
      r_div_qneg  <= 1'b0;
      r_div_rneg  <= 1'b0;
      r_div_zero  <= 1'b0;
    end else begin
      case (r_div_state)
        DIV_IDLE: begin
          if (w_is_div_any) begin
            r_div_state <= DIV_BUSY;
            r_div_cnt   <= '0;
            r_div_rem   <= '0;
            r_div_quo   <= w_abs1;
            r_div_dvsr  <= w_abs2;
            r_div_qneg  <= w_is_div && (w_rdata1[31] ^ w_rdata2[31]);
            r_div_rneg  <= w_is_div && w_rdata1[31];
            r_div_zero  <= (w_rdata2 == 32'd0);
          end
        end
        DIV_BUSY: begin
          r_div_rem <= w_div_ge ? w_div_diff[31:0] : w_div_shift[31:0];
          r_div_quo <= {r_div_quo[30:0], w_div_ge};
          if (r_div_cnt == 5'd31) begin
            r_div_state <= DIV_DONE;
          end else begin
            r_div_cnt <= r_div_cnt + 5'd1;
          end
        end
        DIV_DONE: begin
          if (w_id_load) r_div_state <= DIV_IDLE;
        end
        default: r_div_state <= DIV_IDLE;
      endcase
    end
  end

  // HI/LO commit only as the writer leaves EX, which orders them against a following mfhi/mflo
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (stall[3] == NOSTOP) begin
      if (w_is_mthi) r_hi <= w_rdata1;
      if (w_is_mtlo) r_lo <= w_rdata1;
      if (w_is_div_any && r_div_state == DIV_DONE) begin
        r_hi <= w_div_rem_fin;
        r_lo <= w_div_quo_fin;
      end
    end
  end

  assign stallreq_for_ex = ((r_div_state == DIV_IDLE) && w_is_div_any) || (r_div_state == DIV_BUSY);
  assign ex_is_load      = w_ram_en & w_sel_rf_res;
  assign data_sram_en    = w_ram_en & ~stallreq_for_ex;
  assign data_sram_wen   = w_wen;
  assign data_sram_addr  = w_addr;
  assign data_sram_wdata = w_wdata;
  assign ex_to_rf_bus    = {w_rf_we, w_rf_waddr, w_ex_result};
  assign ex_to_mem_bus   = {w_pc, w_ram_en, w_ram_wen, w_sel_rf_res, w_rf_we, w_rf_waddr, w_ex_result};

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: expectations are queued with each step and
// compared against the DUT once the instruction sits in EX.
module tb_ex_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   stall;
  logic [158:0] id_to_ex_bus;
  logic [75:0]  ex_to_mem_bus;
  logic [37:0]  ex_to_rf_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;
  logic         stallreq_for_ex;
  logic         ex_is_load;

  ex_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .id_to_ex_bus    (id_to_ex_bus),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .ex_to_rf_bus    (ex_to_rf_bus),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .stallreq_for_ex (stallreq_for_ex),
    .ex_is_load      (ex_is_load)
  );

  always #5 clk = ~clk;

  localparam logic [11:0] OP_ADD  = 12'b1000_0000_0000;
  localparam logic [11:0] OP_SUB  = 12'b0100_0000_0000;
  localparam logic [11:0] OP_SLT  = 12'b0010_0000_0000;
  localparam logic [11:0] OP_SLTU = 12'b0001_0000_0000;
  localparam logic [11:0] OP_SRA  = 12'b0000_0000_0010;
  localparam logic [11:0] OP_NONE = 12'b0000_0000_0000;

  localparam int SEL_RF     = 0;
  localparam int SEL_MEM    = 1;
  localparam int SEL_ADDR   = 2;
  localparam int SEL_WEN    = 3;
  localparam int SEL_WDATA  = 4;
  localparam int SEL_EN     = 5;
  localparam int SEL_ISLOAD = 6;
  localparam int SEL_STALL  = 7;
  localparam int SEL_ALL    = 8;

  int nCompared   = 0;
  int nMismatched = 0;

  string        tagQ[$];
  int           selQ[$];
  logic [191:0] valQ[$];

  function automatic logic [158:0] mkBus(
    input logic [31:0] pc, input logic [31:0] inst, input logic [11:0] op,
    input logic [2:0] s1, input logic [3:0] s2, input logic ramEn, input logic [3:0] ramWen,
    input logic rfWe, input logic [4:0] waddr, input logic selRes,
    input logic [31:0] rd1, input logic [31:0] rd2);
    return {pc, inst, op, s1, s2, ramEn, ramWen, rfWe, waddr, selRes, rd1, rd2};
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sa,
                                        input logic [5:0] func);
    return {6'b000000, rs, rt, rd, sa, func};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [191:0] rfExp(input logic we, input logic [4:0] waddr,
                                         input logic [31:0] res);
    return 192'({we, waddr, res});
  endfunction

  function automatic logic [191:0] observe(input int sel);
    case (sel)
      SEL_RF:     return 192'(ex_to_rf_bus);
      SEL_MEM:    return 192'(ex_to_mem_bus);
      SEL_ADDR:   return 192'(data_sram_addr);
      SEL_WEN:    return 192'(data_sram_wen);
      SEL_WDATA:  return 192'(data_sram_wdata);
      SEL_EN:     return 192'(data_sram_en);
      SEL_ISLOAD: return 192'(ex_is_load);
      SEL_STALL:  return 192'(stallreq_for_ex);
      default:    return 192'({ex_to_mem_bus, ex_to_rf_bus, data_sram_en, data_sram_wen,
                               data_sram_addr, data_sram_wdata, stallreq_for_ex, ex_is_load});
    endcase
  endfunction

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pushExp(input string tag, input int sel, input logic [191:0] v);
    tagQ.push_back(tag);
    selQ.push_back(sel);
    valQ.push_back(v);
  endtask

  task automatic applyStimulus(input logic [158:0] bus, input logic [5:0] st);
    id_to_ex_bus = bus;
    stall        = st;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput();
    while (tagQ.size() > 0) begin
      check(tagQ.pop_front(), observe(selQ.pop_front()), valQ.pop_front());
    end
  endtask

  // Issues a divide, plays controller while it stalls, then holds extra DONE cycles
  task automatic runDiv(input string tag, input logic uns, input logic [31:0] rd1,
                        input logic [31:0] rd2, input int holdCycles);
    int n;
    int guard;
    applyStimulus(mkBus(32'h0000_0100, rtype(5'd1, 5'd2, 5'd0, 5'd0, uns ? 6'b011011 : 6'b011010),
                        OP_NONE, 3'b000, 4'b0000, 1'b0, 4'b0000, 1'b0, 5'd0, 1'b0, rd1, rd2),
                  6'b000000);
    stall = 6'b001111;
    n     = 0;
    guard = 0;
    while (stallreq_for_ex && guard < 100) begin
      n++;
      guard++;
      @(posedge clk);
      #1;
    end
    check({tag, "_stall_cycles"}, 192'(n), 192'(33));
    for (int i = 0; i < holdCycles; i++) begin
      @(posedge clk);
      #1;
      check({tag, "_done_hold_no_restart"}, observe(SEL_STALL), 192'(0));
    end
  endtask

  logic [158:0] mfhiBus;
  logic [158:0] mfloBus;
  logic [158:0] addiuBus;

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: observed no finish, required finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    mfhiBus  = mkBus(32'h0000_0200, rtype(5'd0, 5'd0, 5'd7, 5'd0, 6'b010000), OP_NONE,
                     3'b000, 4'b0000, 1'b0, 4'b0000, 1'b1, 5'd7, 1'b0, 32'd0, 32'd0);
    mfloBus  = mkBus(32'h0000_0204, rtype(5'd0, 5'd0, 5'd8, 5'd0, 6'b010010), OP_NONE,
                     3'b000, 4'b0000, 1'b0, 4'b0000, 1'b1, 5'd8, 1'b0, 32'd0, 32'd0);
    addiuBus = mkBus(32'h0000_0004, itype(6'b001001, 5'd0, 5'd2, 16'd5), OP_ADD,
                     3'b001, 4'b0010, 1'b0, 4'b0000, 1'b1, 5'd2, 1'b0, 32'd0, 32'd0);

    rst          = 1'b0;
    stall        = 6'b000000;
    id_to_ex_bus = mkBus(32'h1234_5678, 32'hFFFF_FFFF, OP_ADD, 3'b001, 4'b0001, 1'b1,
                         4'b1111, 1'b1, 5'd31, 1'b1, 32'h1, 32'h2);
    @(posedge clk);
    #1;
    check("reset_all_outputs", observe(SEL_ALL), 192'(0));
    @(negedge clk);
    rst = 1'b1;

    pushExp("addiu_rf_bus", SEL_RF, rfExp(1'b1, 5'd2, 32'd5));
    applyStimulus(addiuBus, 6'b000000);
    checkOutput();

    pushExp("sub_wrap", SEL_RF, rfExp(1'b1, 5'd3, 32'h7FFF_FFFF));
    applyStimulus(mkBus(32'h8, rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'b100011), OP_SUB, 3'b001, 4'b0001,
                        1'b0, 4'b0000, 1'b1, 5'd3, 1'b0, 32'h8000_0000, 32'd1), 6'b000000);
    checkOutput();

    pushExp("slt_neg1_vs_1", SEL_RF, rfExp(1'b1, 5'd4, 32'd1));
    applyStimulus(mkBus(32'hC, rtype(5'd1, 5'd2, 5'd4, 5'd0, 6'b101010), OP_SLT, 3'b001, 4'b0001,
                        1'b0, 4'b0000, 1'b1, 5'd4, 1'b0, 32'hFFFF_FFFF, 32'd1), 6'b000000);
    checkOutput();

    pushExp("sltu_neg1_vs_1", SEL_RF, rfExp(1'b1, 5'd4, 32'd0));
    applyStimulus(mkBus(32'h10, rtype(5'd1, 5'd2, 5'd4, 5'd0, 6'b101011), OP_SLTU, 3'b001, 4'b0001,
                        1'b0, 4'b0000, 1'b1, 5'd4, 1'b0, 32'hFFFF_FFFF, 32'd1), 6'b000000);
    checkOutput();

    pushExp("sra_by4", SEL_RF, rfExp(1'b1, 5'd5, 32'hF800_0000));
    applyStimulus(mkBus(32'h14, rtype(5'd0, 5'd2, 5'd5, 5'd4, 6'b000011), OP_SRA, 3'b100, 4'b0001,
                        1'b0, 4'b0000, 1'b1, 5'd5, 1'b0, 32'd0, 32'h8000_0000), 6'b000000);
    checkOutput();

    pushExp("sb_addr", SEL_ADDR, 192'(32'h0000_1003));
    pushExp("sb_wen", SEL_WEN, 192'(4'b1000));
    pushExp("sb_wdata", SEL_WDATA, 192'(32'hABAB_ABAB));
    pushExp("sb_sram_en", SEL_EN, 192'(1));
    pushExp("sb_not_load", SEL_ISLOAD, 192'(0));
    applyStimulus(mkBus(32'h18, itype(6'b101000, 5'd1, 5'd2, 16'd3), OP_ADD, 3'b001, 4'b0010,
                        1'b1, 4'b0001, 1'b0, 5'd0, 1'b0, 32'h0000_1000, 32'h0000_00AB), 6'b000000);
    checkOutput();

    pushExp("sh_wen", SEL_WEN, 192'(4'b1100));
    pushExp("sh_wdata", SEL_WDATA, 192'(32'h1234_1234));
    applyStimulus(mkBus(32'h1C, itype(6'b101001, 5'd1, 5'd2, 16'd2), OP_ADD, 3'b001, 4'b0010,
                        1'b1, 4'b0011, 1'b0, 5'd0, 1'b0, 32'h0000_1000, 32'h0000_1234), 6'b000000);
    checkOutput();

    pushExp("lw_wen", SEL_WEN, 192'(4'b0000));
    pushExp("lw_is_load", SEL_ISLOAD, 192'(1));
    pushExp("lw_addr", SEL_ADDR, 192'(32'h0000_2004));
    applyStimulus(mkBus(32'h20, itype(6'b100011, 5'd1, 5'd6, 16'd4), OP_ADD, 3'b001, 4'b0010,
                        1'b1, 4'b0000, 1'b1, 5'd6, 1'b1, 32'h0000_2000, 32'd0), 6'b000000);
    checkOutput();

    pushExp("bubble_mem_bus", SEL_MEM, 192'(0));
    pushExp("bubble_is_load", SEL_ISLOAD, 192'(0));
    applyStimulus(addiuBus, 6'b000100);
    checkOutput();

    applyStimulus(mkBus(32'h24, rtype(5'd1, 5'd0, 5'd0, 5'd0, 6'b010001), OP_NONE, 3'b000, 4'b0000,
                        1'b0, 4'b0000, 1'b0, 5'd0, 1'b0, 32'hDEAD_BEEF, 32'd0), 6'b000000);
    pushExp("mfhi_after_mthi", SEL_RF, rfExp(1'b1, 5'd7, 32'hDEAD_BEEF));
    applyStimulus(mfhiBus, 6'b000000);
    checkOutput();

    runDiv("div_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 3);
    pushExp("div_mflo", SEL_RF, rfExp(1'b1, 5'd8, 32'hFFFF_FFFD));
    applyStimulus(mfloBus, 6'b000000);
    checkOutput();
    pushExp("div_mfhi", SEL_RF, rfExp(1'b1, 5'd7, 32'hFFFF_FFFF));
    applyStimulus(mfhiBus, 6'b000000);
    checkOutput();

    runDiv("divu_max_16", 1'b1, 32'hFFFF_FFFF, 32'd16, 0);
    pushExp("divu_mflo", SEL_RF, rfExp(1'b1, 5'd8, 32'h0FFF_FFFF));
    applyStimulus(mfloBus, 6'b000000);
    checkOutput();
    pushExp("divu_mfhi", SEL_RF, rfExp(1'b1, 5'd7, 32'd15));
    applyStimulus(mfhiBus, 6'b000000);
    checkOutput();

    runDiv("div_by_zero", 1'b0, 32'd9, 32'd0, 1);
    pushExp("divz_mflo", SEL_RF, rfExp(1'b1, 5'd8, 32'hFFFF_FFFF));
    applyStimulus(mfloBus, 6'b000000);
    checkOutput();
    pushExp("divz_mfhi", SEL_RF, rfExp(1'b1, 5'd7, 32'd9));
    applyStimulus(mfhiBus, 6'b000000);
    checkOutput();

    applyStimulus(mkBus(32'h300, rtype(5'd1, 5'd2, 5'd0, 5'd0, 6'b011010), OP_NONE, 3'b000, 4'b0000,
                        1'b0, 4'b0000, 1'b0, 5'd0, 1'b0, 32'd100, 32'd3), 6'b000000);
    stall = 6'b001111;
    repeat (5) @(posedge clk);
    #1;
    check("mid_div_busy", observe(SEL_STALL), 192'(1));
    rst = 1'b0;
    #1;
    check("mid_div_reset_outputs", observe(SEL_ALL), 192'(0));
    id_to_ex_bus = '0;
    stall        = 6'b000000;
    @(negedge clk);
    rst = 1'b1;
    pushExp("post_reset_addiu", SEL_RF, rfExp(1'b1, 5'd2, 32'd5));
    applyStimulus(addiuBus, 6'b000000);
    checkOutput();
    pushExp("post_reset_hi", SEL_RF, rfExp(1'b1, 5'd7, 32'd0));
    applyStimulus(mfhiBus, 6'b000000);
    checkOutput();
    pushExp("post_reset_lo", SEL_RF, rfExp(1'b1, 5'd8, 32'd0));
    applyStimulus(mfloBus, 6'b000000);
    checkOutput();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
